// File: rtl/alu_pkg.sv
// Shared opcodes and flag type for the execute-stage ALU.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/alu_exec_unit_core.sv
// Combinational ALU datapath: result, NZCV flags and illegal-code detection.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags,
  output logic             illegal
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] sub_sum;
  logic           add_ovf;
  logic           sub_ovf;
  logic           carry;
  logic           ovf;

  // Both sums are always formed; subtract is A + ~B + 1 so carry-out means "no borrow".
  always_comb begin
    add_sum = {1'b0, src_a} + {1'b0, src_b};
    sub_sum = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};
    add_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (add_sum[WIDTH-1] != src_a[WIDTH-1]);
    sub_ovf = (src_a[WIDTH-1] == ~src_b[WIDTH-1]) && (sub_sum[WIDTH-1] != src_a[WIDTH-1]);
    result  = {WIDTH{1'b0}};
    carry   = 1'b0;
    ovf     = 1'b0;
    illegal = 1'b0;
    case (alu_control)
      ALU_ADD: begin
        result = add_sum[WIDTH-1:0];
        carry  = add_sum[WIDTH];
        ovf    = add_ovf;
      end
      ALU_SUB: begin
        result = sub_sum[WIDTH-1:0];
        carry  = sub_sum[WIDTH];
        ovf    = sub_ovf;
      end
      ALU_AND: result = src_a & src_b;
      ALU_OR:  result = src_a | src_b;
      ALU_SLT: begin
        result = {{(WIDTH-1){1'b0}}, sub_sum[WIDTH-1] ^ sub_ovf};
        carry  = sub_sum[WIDTH];
        ovf    = sub_ovf;
      end
      default: illegal = 1'b1;
    endcase
    flags.n = result[WIDTH-1];
    flags.z = (result == {WIDTH{1'b0}});
    flags.c = carry;
    flags.v = ovf;
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU wrapper: valid/ready input, output register plus one-entry skid buffer.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             illegal
);

  logic [WIDTH-1:0] core_result;
  alu_flags_t       core_flags;
  logic             core_illegal;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .result      (core_result),
    .flags       (core_flags),
    .illegal     (core_illegal)
  );

  logic             or_valid_q,   or_valid_d;
  logic [WIDTH-1:0] or_result_q,  or_result_d;
  alu_flags_t       or_flags_q,   or_flags_d;
  logic             or_illegal_q, or_illegal_d;
  logic             sk_valid_q,   sk_valid_d;
  logic [WIDTH-1:0] sk_result_q,  sk_result_d;
  alu_flags_t       sk_flags_q,   sk_flags_d;
  logic             sk_illegal_q, sk_illegal_d;
  logic             accept;
  logic             consume;

  // Next-state for OR/SK; an accept always finds SK empty because in_ready = !SK valid.
  always_comb begin
    accept       = in_valid && !sk_valid_q;
    consume      = or_valid_q && out_ready;
    or_valid_d   = or_valid_q;
    or_result_d  = or_result_q;
    or_flags_d   = or_flags_q;
    or_illegal_d = or_illegal_q;
    sk_valid_d   = sk_valid_q;
    sk_result_d  = sk_result_q;
    sk_flags_d   = sk_flags_q;
    sk_illegal_d = sk_illegal_q;
    if (accept) begin
      if (!or_valid_q || out_ready) begin
        or_valid_d   = 1'b1;
        or_result_d  = core_result;
        or_flags_d   = core_flags;
        or_illegal_d = core_illegal;
      end else begin
        sk_valid_d   = 1'b1;
        sk_result_d  = core_result;
        sk_flags_d   = core_flags;
        sk_illegal_d = core_illegal;
      end
    end else if (consume) begin
      if (sk_valid_q) begin
        or_result_d  = sk_result_q;
        or_flags_d   = sk_flags_q;
        or_illegal_d = sk_illegal_q;
        sk_valid_d   = 1'b0;
      end else begin
        or_valid_d   = 1'b0;
      end
    end else begin
      or_valid_d = or_valid_q;
    end
  end

  // State registers; reset clears both slots and their payloads.
  always_ff @(posedge clk) begin
    if (rst) begin
      or_valid_q   <= 1'b0;
      or_result_q  <= {WIDTH{1'b0}};
      or_flags_q   <= alu_flags_t'(4'b0000);
      or_illegal_q <= 1'b0;
      sk_valid_q   <= 1'b0;
      sk_result_q  <= {WIDTH{1'b0}};
      sk_flags_q   <= alu_flags_t'(4'b0000);
      sk_illegal_q <= 1'b0;
    end else begin
      or_valid_q   <= or_valid_d;
      or_result_q  <= or_result_d;
      or_flags_q   <= or_flags_d;
      or_illegal_q <= or_illegal_d;
      sk_valid_q   <= sk_valid_d;
      sk_result_q  <= sk_result_d;
      sk_flags_q   <= sk_flags_d;
      sk_illegal_q <= sk_illegal_d;
    end
  end

  assign in_ready  = !sk_valid_q;
  assign out_valid = or_valid_q;
  assign result    = or_result_q;
  assign flag_n    = or_flags_q.n;
  assign flag_z    = or_flags_q.z;
  assign flag_c    = or_flags_q.c;
  assign flag_v    = or_flags_q.v;
  assign illegal   = or_illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed vectors, backpressure and mid-stream reset.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  alu_control = 3'b000;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        flag_n, flag_z, flag_c, flag_v, illegal;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [36:0] sb_q[$];
  logic        hold_prev = 1'b0;
  logic [36:0] bundle_prev = 37'd0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .illegal(illegal)
  );

  function automatic logic [36:0] bnd(logic [31:0] r, logic [3:0] nzcv, logic il);
    return {r, nzcv, il};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Issue one bundle; the expected response is queued on the accept edge.
  task automatic send(logic [2:0] ctl, logic [31:0] a, logic [31:0] b, logic [36:0] exp);
    logic rdy;
    bit   done;
    done = 1'b0;
    in_valid = 1'b1; alu_control = ctl; src_a = a; src_b = b;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        sb_q.push_back(exp);
        done = 1'b1;
      end
    end
    if (!done) check("send_timeout", 64'd1, 64'd0);
    #1;
  endtask

  // Monitor: pop and compare on every transfer, and check hold stability under backpressure.
  always @(negedge clk) begin
    logic [36:0] cur;
    cur = {result, flag_n, flag_z, flag_c, flag_v, illegal};
    if (!rst && hold_prev) check("hold_stable", {27'd0, cur}, {27'd0, bundle_prev});
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) check("unexpected_output", {27'd0, cur}, 64'd0);
      else check("sb_bundle", {27'd0, cur}, {27'd0, sb_q.pop_front()});
    end
    hold_prev   = !rst && out_valid && !out_ready;
    bundle_prev = cur;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_bundle", {27'd0, result, flag_n, flag_z, flag_c, flag_v, illegal}, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Streamed with out_ready = 1; first vector also checks 1-cycle latency.
    send(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, bnd(32'h0, 4'b0110, 1'b0));
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_out_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    send(3'b000, 32'h7FFF_FFFF, 32'h0000_0001, bnd(32'h8000_0000, 4'b1001, 1'b0));
    send(3'b001, 32'h8000_0000, 32'h0000_0001, bnd(32'h7FFF_FFFF, 4'b0011, 1'b0));
    send(3'b001, 32'h0000_0003, 32'h0000_0005, bnd(32'hFFFF_FFFE, 4'b1000, 1'b0));
    send(3'b101, 32'hFFFF_FFFF, 32'h0000_0001, bnd(32'h0000_0001, 4'b0010, 1'b0));
    send(3'b101, 32'h0000_0001, 32'hFFFF_FFFF, bnd(32'h0000_0000, 4'b0100, 1'b0));
    send(3'b010, 32'h0000_F0F0, 32'h0000_0FF0, bnd(32'h0000_00F0, 4'b0000, 1'b0));
    send(3'b011, 32'h0000_F0F0, 32'h0000_0FF0, bnd(32'h0000_FFF0, 4'b0000, 1'b0));
    send(3'b110, 32'h0000_0005, 32'h0000_0007, bnd(32'h0, 4'b0100, 1'b1));
    send(3'b100, 32'h0000_0005, 32'h0000_0007, bnd(32'h0, 4'b0100, 1'b1));
    send(3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bnd(32'h0, 4'b0100, 1'b1));
    in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Backpressure: two accepts fill OR and SK, the third waits upstream.
    out_ready = 1'b0;
    send(3'b000, 32'd1, 32'd1, bnd(32'd2, 4'b0000, 1'b0));
    send(3'b000, 32'd2, 32'd2, bnd(32'd4, 4'b0000, 1'b0));
    fork
      send(3'b000, 32'd3, 32'd3, bnd(32'd6, 4'b0000, 1'b0));
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
          check("bp_out_valid", {63'd0, out_valid}, 64'd1);
          check("bp_head_result", {32'd0, result}, 64'd2);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("bp_no_gap", {63'd0, out_valid}, 64'd1);
          @(posedge clk);
        end
      end
    join
    in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Reset with OR and SK both full: bundles are discarded.
    out_ready = 1'b0;
    send(3'b000, 32'd10, 32'd10, bnd(32'd20, 4'b0000, 1'b0));
    send(3'b000, 32'd20, 32'd20, bnd(32'd40, 4'b0000, 1'b0));
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_sk_full", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b1; alu_control = 3'b000; src_a = 32'd99; src_b = 32'd1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_bundle", {27'd0, result, flag_n, flag_z, flag_c, flag_v, illegal}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rst_no_stale", {63'd0, out_valid}, 64'd0);
    end
    @(posedge clk); #1;
    send(3'b001, 32'd7, 32'd7, bnd(32'd0, 4'b0110, 1'b0));
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
